digital_lock_param: RTL and testbench



---
 rtl/digital_lock_param.sv | 235 +++++++++++++++++++++++
 tb/tb_digital_lock_param.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digital_lock_param.sv
// digital_lock_param: parameterised BCD combination lock.
// The user builds a code one digit at a time (sel/inc/confirm) and submits it
// with enter. Repeated wrong codes trigger a timed lockout; a master code
// always unlocks; while unlocked with mode=1, enter stores a new user code.
module digital_lock_param #(
    parameter int                    N_DIGITS     = 4,
    parameter int                    MAX_FAIL     = 3,
    parameter int                    LOCK_CYCLES  = 1000,
    parameter logic [4*N_DIGITS-1:0] DEFAULT_CODE = 16'h1234,
    parameter logic [4*N_DIGITS-1:0] MASTER_CODE  = 16'h9999
) (
    input  logic                        clk,
    input  logic                        rst_btn,
    input  logic                        sel_btn,
    input  logic                        inc_btn,
    input  logic                        confirm,
    input  logic                        enter,
    input  logic                        mode,
    output logic [2:0]                  led_rgb,
    output logic [4*N_DIGITS-1:0]       entry_out,
    output logic [$clog2(N_DIGITS):0]   led_pos,
    output logic [3:0]                  led_digit,
    output logic [3:0]                  led_fail,
    output logic                        led_mode,
    output logic                        pgm_done
);

    localparam int CW = 4 * N_DIGITS;
    localparam int PW = $clog2(N_DIGITS);
    localparam int TW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t          state;
    state_t          nxt_state;
    logic [CW-1:0]   stored;
    logic [CW-1:0]   entry;
    logic [CW-1:0]   entry_wr;
    logic [3:0]      digit;
    logic [3:0]      digit_inc;
    logic [PW-1:0]   pos;
    logic [PW-1:0]   pos_wrap;
    logic            pos_valid;
    logic [3:0]      fail;
    logic [3:0]      fail_inc;
    logic            fail_max;
    logic [TW-1:0]   timer;
    logic            timer_done;
    logic [2:0]      rgb_nxt;

    logic            prev_sel;
    logic            prev_inc;
    logic            prev_cfm;
    logic            prev_ent;
    logic            rise_sel;
    logic            rise_inc;
    logic            rise_cfm;
    logic            rise_ent;
    logic            ev_enter;
    logic            ev_confirm;
    logic            ev_sel;
    logic            ev_inc;
    logic            hit_user;
    logic            hit_master;

    // Button level history for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            prev_sel <= 1'b0;
            prev_inc <= 1'b0;
            prev_cfm <= 1'b0;
            prev_ent <= 1'b0;
        end else begin
            prev_sel <= sel_btn;
            prev_inc <= inc_btn;
            prev_cfm <= confirm;
            prev_ent <= enter;
        end
    end

    // Edge detection and same-cycle priority: enter > confirm > sel > inc
    always_comb begin
        rise_sel   = sel_btn & ~prev_sel;
        rise_inc   = inc_btn & ~prev_inc;
        rise_cfm   = confirm & ~prev_cfm;
        rise_ent   = enter   & ~prev_ent;
        ev_enter   = rise_ent;
        ev_confirm = rise_cfm & ~rise_ent;
        ev_sel     = rise_sel & ~rise_ent & ~rise_cfm;
        ev_inc     = rise_inc & ~rise_ent & ~rise_cfm & ~rise_sel;
    end

    // Digit editing helpers: wrapped counters and the buffer with nibble[pos] replaced
    always_comb begin
        digit_inc = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        pos_wrap  = (pos == PW'(N_DIGITS - 1)) ? '0 : pos + PW'(1);
        entry_wr  = entry;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (pos == PW'(i)) begin
                entry_wr[CW-4-4*i +: 4] = digit;
            end
        end
    end

    // Code comparison, fail/timer status flags
    always_comb begin
        hit_user   = (entry == stored);
        hit_master = (entry == MASTER_CODE);
        fail_inc   = fail + 4'd1;
        fail_max   = (fail_inc == 4'(MAX_FAIL));
        timer_done = (timer <= TW'(1));
    end

    // Next-state decision; a master enter beats the lockout timeout
    always_comb begin
        nxt_state = state;
        case (state)
            ST_LOCKED: begin
                if (ev_enter) begin
                    if (hit_user || hit_master) begin
                        nxt_state = ST_UNLOCKED;
                    end else if (fail_max) begin
                        nxt_state = ST_LOCKOUT;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (ev_enter && hit_master) begin
                    nxt_state = ST_UNLOCKED;
                end else if (timer_done) begin
                    nxt_state = ST_LOCKED;
                end
            end
            ST_UNLOCKED: begin
                if (ev_enter && !mode) begin
                    nxt_state = ST_LOCKED;
                end
            end
            default: nxt_state = ST_LOCKED;
        endcase
    end

    // LED colour for the state being entered
    always_comb begin
        rgb_nxt = 3'b100;
        case (nxt_state)
            ST_LOCKED:   rgb_nxt = 3'b100;
            ST_UNLOCKED: rgb_nxt = mode ? 3'b011 : 3'b010;
            ST_LOCKOUT:  rgb_nxt = 3'b001;
            default:     rgb_nxt = 3'b100;
        endcase
    end

    // Main FSM: state, entry editing, fail count, lockout timer, registered outputs
    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            state     <= ST_LOCKED;
            stored    <= DEFAULT_CODE;
            entry     <= '0;
            digit     <= '0;
            pos       <= '0;
            pos_valid <= 1'b0;
            fail      <= '0;
            timer     <= '0;
            pgm_done  <= 1'b0;
            led_rgb   <= 3'b100;
            led_mode  <= 1'b0;
        end else begin
            state    <= nxt_state;
            led_rgb  <= rgb_nxt;
            led_mode <= mode;
            pgm_done <= 1'b0;

            // Entry editing; enter clears after the evaluation below has used the buffer
            if (ev_enter) begin
                entry     <= '0;
                digit     <= '0;
                pos_valid <= 1'b0;
            end else if (ev_confirm) begin
                if (pos_valid) begin
                    entry <= entry_wr;
                end
            end else if (ev_sel) begin
                digit     <= '0;
                pos       <= pos_valid ? pos_wrap : '0;
                pos_valid <= 1'b1;
            end else if (ev_inc && pos_valid) begin
                digit <= digit_inc;
            end

            case (state)
                ST_LOCKED: begin
                    if (ev_enter) begin
                        if (hit_user || hit_master) begin
                            fail <= '0;
                        end else begin
                            fail <= fail_inc;
                            if (fail_max) begin
                                timer <= TW'(LOCK_CYCLES);
                            end
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if ((ev_enter && hit_master) || timer_done) begin
                        fail  <= '0;
                        timer <= '0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_UNLOCKED: begin
                    if (ev_enter && mode) begin
                        stored   <= entry;
                        pgm_done <= 1'b1;
                    end
                end
                default: begin
                    fail  <= '0;
                    timer <= '0;
                end
            endcase
        end
    end

    assign entry_out = entry;
    assign led_pos   = {pos_valid, pos};
    assign led_digit = digit;
    assign led_fail  = fail;

endmodule

// File: tb/tb_digital_lock_param.sv
// Testbench for digital_lock_param: two instances share stimulus, one with a
// short lockout (20 cycles) and one with a long lockout (300 cycles) so that a
// full master code can be keyed in while still locked out.
module tb_digital_lock_param;

    localparam int          LC0  = 20;
    localparam int          LC1  = 300;
    localparam int          MAXF = 3;
    localparam int          MSTV = 'h999;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_btn, sel_btn, inc_btn, confirm, enter, mode;
    logic [2:0]  rgb0, rgb1, pos0, pos1;
    logic [11:0] ent0, ent1;
    logic [3:0]  dig0, dig1, fail0, fail1;
    logic        lm0, lm1, pg0, pg1;

    digital_lock_param #(
        .N_DIGITS(3), .MAX_FAIL(MAXF), .LOCK_CYCLES(LC0),
        .DEFAULT_CODE(12'h121), .MASTER_CODE(12'h999)
    ) u_dut0 (
        .clk(clk), .rst_btn(rst_btn), .sel_btn(sel_btn), .inc_btn(inc_btn),
        .confirm(confirm), .enter(enter), .mode(mode),
        .led_rgb(rgb0), .entry_out(ent0), .led_pos(pos0), .led_digit(dig0),
        .led_fail(fail0), .led_mode(lm0), .pgm_done(pg0)
    );

    digital_lock_param #(
        .N_DIGITS(3), .MAX_FAIL(MAXF), .LOCK_CYCLES(LC1),
        .DEFAULT_CODE(12'h121), .MASTER_CODE(12'h999)
    ) u_dut1 (
        .clk(clk), .rst_btn(rst_btn), .sel_btn(sel_btn), .inc_btn(inc_btn),
        .confirm(confirm), .enter(enter), .mode(mode),
        .led_rgb(rgb1), .entry_out(ent1), .led_pos(pos1), .led_digit(dig1),
        .led_fail(fail1), .led_mode(lm1), .pgm_done(pg1)
    );

    int checks = 0;
    int errors = 0;
    int pgm_count0 = 0;
    bit cur_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int S_LK = 0, S_UN = 1, S_LO = 2;
    int m_state[2];
    int m_ent[2][3];
    int m_sto[2][3];
    int m_dig[2], m_pos[2], m_val[2], m_fail[2], m_left[2], m_pgm[2], m_mode[2];
    int lockc[2] = '{LC0, LC1};
    bit p_sel, p_inc, p_cfm, p_ent;

    function automatic int value3(input int a, input int b, input int c);
        return a * 256 + b * 16 + c;
    endfunction

    function automatic int rgb_of(input int st, input int m);
        if (st == S_LK) return 4;
        if (st == S_LO) return 1;
        return (m != 0) ? 3 : 2;
    endfunction

    task automatic lockout_tick(input int k);
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) begin
            m_state[k] = S_LK;
            m_fail[k] = 0;
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit i, input bit c, input bit e, input bit m);
        int ev;
        int code;
        int sto;
        if (!r) begin
            for (int k = 0; k < 2; k++) begin
                m_state[k] = S_LK;
                m_sto[k][0] = 1; m_sto[k][1] = 2; m_sto[k][2] = 1;
                for (int j = 0; j < 3; j++) m_ent[k][j] = 0;
                m_dig[k] = 0; m_pos[k] = 0; m_val[k] = 0; m_fail[k] = 0;
                m_left[k] = 0; m_pgm[k] = 0; m_mode[k] = 0;
            end
            p_sel = 0; p_inc = 0; p_cfm = 0; p_ent = 0;
            return;
        end
        ev = 0;
        if (i && !p_inc) ev = 1;
        if (s && !p_sel) ev = 2;
        if (c && !p_cfm) ev = 3;
        if (e && !p_ent) ev = 4;
        p_sel = s; p_inc = i; p_cfm = c; p_ent = e;
        for (int k = 0; k < 2; k++) begin
            m_pgm[k] = 0;
            m_mode[k] = m;
            if (ev == 4) begin
                code = value3(m_ent[k][0], m_ent[k][1], m_ent[k][2]);
                sto  = value3(m_sto[k][0], m_sto[k][1], m_sto[k][2]);
                if (m_state[k] == S_LK) begin
                    if (code == sto || code == MSTV) begin
                        m_state[k] = S_UN; m_fail[k] = 0;
                    end else begin
                        m_fail[k]++;
                        if (m_fail[k] == MAXF) begin
                            m_state[k] = S_LO; m_left[k] = lockc[k];
                        end
                    end
                end else if (m_state[k] == S_LO) begin
                    if (code == MSTV) begin
                        m_state[k] = S_UN; m_fail[k] = 0; m_left[k] = 0;
                    end else begin
                        lockout_tick(k);
                    end
                end else begin
                    if (m) begin
                        for (int j = 0; j < 3; j++) m_sto[k][j] = m_ent[k][j];
                        m_pgm[k] = 1;
                    end else begin
                        m_state[k] = S_LK;
                    end
                end
                for (int j = 0; j < 3; j++) m_ent[k][j] = 0;
                m_dig[k] = 0; m_val[k] = 0;
            end else begin
                if (m_state[k] == S_LO) lockout_tick(k);
                if (ev == 3 && m_val[k] != 0) m_ent[k][m_pos[k]] = m_dig[k];
                if (ev == 2) begin
                    m_pos[k] = (m_val[k] != 0) ? (m_pos[k] + 1) % 3 : 0;
                    m_val[k] = 1; m_dig[k] = 0;
                end
                if (ev == 1 && m_val[k] != 0) m_dig[k] = (m_dig[k] + 1) % 10;
            end
        end
    endtask

    task automatic compare_model();
        logic [2:0] a_rgb, a_pos; logic [11:0] a_ent; logic [3:0] a_dig, a_fail; logic a_lm, a_pg;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                a_rgb = rgb0; a_pos = pos0; a_ent = ent0; a_dig = dig0; a_fail = fail0; a_lm = lm0; a_pg = pg0;
            end else begin
                a_rgb = rgb1; a_pos = pos1; a_ent = ent1; a_dig = dig1; a_fail = fail1; a_lm = lm1; a_pg = pg1;
            end
            chk($sformatf("m%0d_rgb", k), 32'(a_rgb), rgb_of(m_state[k], m_mode[k]));
            chk($sformatf("m%0d_entry", k), 32'(a_ent), value3(m_ent[k][0], m_ent[k][1], m_ent[k][2]));
            chk($sformatf("m%0d_pos", k), 32'(a_pos), m_val[k] * 4 + m_pos[k]);
            chk($sformatf("m%0d_digit", k), 32'(a_dig), m_dig[k]);
            chk($sformatf("m%0d_fail", k), 32'(a_fail), m_fail[k]);
            chk($sformatf("m%0d_mode", k), 32'(a_lm), m_mode[k]);
            chk($sformatf("m%0d_pgm", k), 32'(a_pg), m_pgm[k]);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input bit r, input bit s, input bit i, input bit c, input bit e);
        rst_btn = r; sel_btn = s; inc_btn = i; confirm = c; enter = e; mode = cur_mode;
        @(posedge clk);
        model_step(r, s, i, c, e, cur_mode);
        #1;
        if (pg0 === 1'b1) pgm_count0++;
        compare_model();
        @(negedge clk);
    endtask

    task automatic idle();      tick(1, 0, 0, 0, 0); endtask
    task automatic press_sel(); tick(1, 1, 0, 0, 0); idle(); endtask
    task automatic press_inc(); tick(1, 0, 1, 0, 0); idle(); endtask
    task automatic press_cfm(); tick(1, 0, 0, 1, 0); idle(); endtask
    task automatic press_ent(); tick(1, 0, 0, 0, 1); idle(); endtask

    task automatic key_code(input int d0, input int d1, input int d2);
        int d[3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        for (int p = 0; p < 3; p++) begin
            press_sel();
            for (int n = 0; n < d[p]; n++) press_inc();
            press_cfm();
        end
    endtask

    typedef struct {
        bit r, s, i, c, e, m;
        logic [2:0]  rgb;
        logic [3:0]  dig;
        logic [2:0]  pos;
        logic [11:0] ent;
        logic [3:0]  fail;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input bit r, input bit s, input bit i, input bit c, input bit e, input bit m,
                                input logic [2:0] rgb, input logic [3:0] dig, input logic [2:0] pos,
                                input logic [11:0] ent, input logic [3:0] fail);
        vec_t v;
        v.r = r; v.s = s; v.i = i; v.c = c; v.e = e; v.m = m;
        v.rgb = rgb; v.dig = dig; v.pos = pos; v.ent = ent; v.fail = fail;
        return v;
    endfunction

    initial begin
        int n;
        rst_btn = 1'b0; sel_btn = 1'b0; inc_btn = 1'b0; confirm = 1'b0; enter = 1'b0; mode = 1'b0;

        //            r s i c e m   rgb  dig pos  entry    fail
        vt.push_back(mk(0,0,0,0,0,0, 3'd4, 0, 3'd0, 12'h000, 0)); // reset
        vt.push_back(mk(1,1,0,0,0,0, 3'd4, 0, 3'd4, 12'h000, 0)); // sel -> pos 0 valid
        vt.push_back(mk(1,0,0,0,0,0, 3'd4, 0, 3'd4, 12'h000, 0));
        vt.push_back(mk(1,0,1,0,0,0, 3'd4, 1, 3'd4, 12'h000, 0)); // inc
        vt.push_back(mk(1,0,1,0,0,0, 3'd4, 1, 3'd4, 12'h000, 0)); // inc held
        vt.push_back(mk(1,0,0,0,0,0, 3'd4, 1, 3'd4, 12'h000, 0));
        vt.push_back(mk(1,0,1,0,0,0, 3'd4, 2, 3'd4, 12'h000, 0));
        vt.push_back(mk(1,0,0,0,0,0, 3'd4, 2, 3'd4, 12'h000, 0));
        vt.push_back(mk(1,0,0,1,0,0, 3'd4, 2, 3'd4, 12'h200, 0)); // confirm pos 0
        vt.push_back(mk(1,0,0,0,0,0, 3'd4, 2, 3'd4, 12'h200, 0));
        vt.push_back(mk(1,1,0,0,0,0, 3'd4, 0, 3'd5, 12'h200, 0)); // sel -> pos 1
        vt.push_back(mk(1,1,0,0,0,0, 3'd4, 0, 3'd5, 12'h200, 0)); // sel held
        vt.push_back(mk(1,0,0,0,0,0, 3'd4, 0, 3'd5, 12'h200, 0));
        vt.push_back(mk(1,1,1,0,0,0, 3'd4, 0, 3'd6, 12'h200, 0)); // sel beats inc
        vt.push_back(mk(1,0,0,0,0,0, 3'd4, 0, 3'd6, 12'h200, 0));
        vt.push_back(mk(1,0,1,0,0,0, 3'd4, 1, 3'd6, 12'h200, 0));
        vt.push_back(mk(1,0,0,0,0,0, 3'd4, 1, 3'd6, 12'h200, 0));
        vt.push_back(mk(1,0,1,1,0,0, 3'd4, 1, 3'd6, 12'h201, 0)); // confirm beats inc
        vt.push_back(mk(1,0,0,0,0,0, 3'd4, 1, 3'd6, 12'h201, 0));
        vt.push_back(mk(1,0,0,1,1,0, 3'd4, 0, 3'd2, 12'h000, 1)); // enter beats confirm, wrong code
        vt.push_back(mk(1,0,0,0,0,0, 3'd4, 0, 3'd2, 12'h000, 1));
        vt.push_back(mk(1,0,0,0,0,1, 3'd4, 0, 3'd2, 12'h000, 1)); // mode ignored while locked
        vt.push_back(mk(1,1,0,0,0,0, 3'd4, 0, 3'd4, 12'h000, 1)); // sel after enter restarts at pos 0

        @(negedge clk);

        // ---- table-driven vectors ----
        for (int v = 0; v < vt.size(); v++) begin
            cur_mode = vt[v].m;
            tick(vt[v].r, vt[v].s, vt[v].i, vt[v].c, vt[v].e);
            chk($sformatf("vec%0d_rgb", v), 32'(rgb0), 32'(vt[v].rgb));
            chk($sformatf("vec%0d_digit", v), 32'(dig0), 32'(vt[v].dig));
            chk($sformatf("vec%0d_pos", v), 32'(pos0), 32'(vt[v].pos));
            chk($sformatf("vec%0d_entry", v), 32'(ent0), 32'(vt[v].ent));
            chk($sformatf("vec%0d_fail", v), 32'(fail0), 32'(vt[v].fail));
        end
        cur_mode = 1'b0;

        // ---- unlock with the default code ----
        tick(0, 0, 0, 0, 0);
        idle();
        key_code(1, 2, 1);
        press_ent();
        chk("unlock_rgb", 32'(rgb0), 32'd2);
        chk("unlock_fail", 32'(fail0), 32'd0);
        chk("unlock_entry", 32'(ent0), 32'h000);

        // ---- program a new code, then relock and test old/new ----
        cur_mode = 1'b1;
        idle();
        chk("pgm_mode_rgb", 32'(rgb0), 32'd3);
        chk("pgm_led_mode", 32'(lm0), 32'd1);
        pgm_count0 = 0;
        key_code(4, 5, 1);
        press_ent();
        chk("pgm_pulses", 32'(pgm_count0), 32'd1);
        chk("pgm_stay_unlocked", 32'(rgb0), 32'd3);
        cur_mode = 1'b0;
        press_ent();
        chk("relock_rgb", 32'(rgb0), 32'd4);
        key_code(1, 2, 1);
        press_ent();
        chk("old_code_rgb", 32'(rgb0), 32'd4);
        chk("old_code_fail", 32'(fail0), 32'd1);
        key_code(4, 5, 1);
        press_ent();
        chk("new_code_rgb", 32'(rgb0), 32'd2);
        chk("new_code_fail", 32'(fail0), 32'd0);

        // ---- lockout entry, saturation and timeout ----
        press_ent();
        chk("lock_again_rgb", 32'(rgb0), 32'd4);
        press_ent();
        chk("wrong1_fail", 32'(fail0), 32'd1);
        press_ent();
        chk("wrong2_fail", 32'(fail0), 32'd2);
        tick(1, 0, 0, 0, 1);
        chk("wrong3_fail", 32'(fail0), 32'd3);
        chk("lockout_rgb", 32'(rgb0), 32'd1);
        n = 0;
        idle(); n++;
        tick(1, 0, 0, 0, 1); n++;
        chk("lockout_wrong_fail", 32'(fail0), 32'd3);
        chk("lockout_wrong_rgb", 32'(rgb0), 32'd1);
        do begin
            idle(); n++;
        end while (rgb0 === 3'b001 && n < 100);
        chk("lockout_cycles", 32'(n), 32'(LC0));
        chk("timeout_rgb", 32'(rgb0), 32'd4);
        chk("timeout_fail", 32'(fail0), 32'd0);
        chk("long_lockout_rgb", 32'(rgb1), 32'd1);
        chk("long_lockout_fail", 32'(fail1), 32'd3);

        // ---- master code during lockout ----
        press_ent(); press_ent(); press_ent();
        chk("relockout_rgb", 32'(rgb0), 32'd1);
        chk("relockout_fail", 32'(fail0), 32'd3);
        key_code(9, 9, 9);
        chk("pre_master_rgb1", 32'(rgb1), 32'd1);
        tick(1, 0, 0, 0, 1);
        chk("master_rgb1", 32'(rgb1), 32'd2);
        chk("master_fail1", 32'(fail1), 32'd0);
        chk("master_rgb0", 32'(rgb0), 32'd2);
        idle();

        // ---- digit wrap and held button ----
        press_sel();
        for (int k = 0; k < 11; k++) press_inc();
        chk("inc11_digit", 32'(dig0), 32'd1);
        for (int k = 0; k < 5; k++) tick(1, 0, 1, 0, 0);
        chk("inc_held_digit", 32'(dig0), 32'd2);
        idle();

        // ---- enter and confirm together ----
        tick(1, 0, 0, 1, 1);
        chk("ent_cfm_entry", 32'(ent0), 32'h000);
        chk("ent_cfm_digit", 32'(dig0), 32'd0);
        chk("ent_cfm_pos_valid", 32'(pos0[2]), 32'd0);
        chk("ent_cfm_rgb", 32'(rgb0), 32'd4);
        idle();

        // ---- reset during lockout restores the default code ----
        press_ent(); press_ent(); press_ent();
        chk("pre_reset_rgb", 32'(rgb0), 32'd1);
        tick(0, 0, 0, 0, 0);
        chk("reset_rgb0", 32'(rgb0), 32'd4);
        chk("reset_rgb1", 32'(rgb1), 32'd4);
        chk("reset_fail", 32'(fail0), 32'd0);
        idle();
        key_code(1, 2, 1);
        press_ent();
        chk("default_restored_rgb", 32'(rgb0), 32'd2);

        // ---- randomized stimulus against the model ----
        for (int t = 0; t < 3000; t++) begin
            bit r, s, i, c, e;
            if ($urandom_range(0, 19) == 0) cur_mode = ~cur_mode;
            r = ($urandom_range(0, 399) != 0);
            s = ($urandom_range(0, 3) == 0);
            i = ($urandom_range(0, 1) == 0);
            c = ($urandom_range(0, 4) == 0);
            e = ($urandom_range(0, 14) == 0);
            tick(r, s, i, c, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
